// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle datapath and its sequencer.
// The datapath side uses master; the sequencer uses slave.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_src;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             alu_src_b;
    logic [1:0]       alu_op;
    logic             illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    modport master (
        output opcode, zero, mem_ready,
        input  pc_write, pc_src, ir_write, mem_read, mem_write,
        input  reg_write, mem_to_reg, alu_src_b, alu_op, illegal,
        input  state, cycle_cnt, instret_cnt
    );

    modport slave (
        input  opcode, zero, mem_ready,
        output pc_write, pc_src, ir_write, mem_read, mem_write,
        output reg_write, mem_to_reg, alu_src_b, alu_op, illegal,
        output state, cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// IF/ID/EX/MEM/WB sequencer for the multicycle RV32I datapath.
// Optional perf counters: define MC_CTRL_PERF_CNT_EN.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.slave   bus
);
    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [6:0] op_q;
    logic       id_legal;
    logic       is_r;
    logic       is_i;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;

    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;

    assign is_r   = (op_q == OP_R);
    assign is_i   = (op_q == OP_I);
    assign is_lw  = (op_q == OP_LW);
    assign is_sw  = (op_q == OP_SW);
    assign is_beq = (op_q == OP_BEQ);

    // Legality of the opcode presented by the IR during decode
    always_comb begin
        id_legal = 1'b0;
        case (bus.opcode)
            OP_R, OP_I, OP_LW, OP_SW, OP_BEQ: id_legal = 1'b1;
            default:                          id_legal = 1'b0;
        endcase
    end

    // State register; the opcode is latched while in decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IF;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) begin
                op_q <= bus.opcode;
            end
        end
    end

    // Next-state selection; memory phases wait for mem_ready
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF: begin
                state_d = bus.mem_ready ? S_ID : S_IF;
            end
            S_ID: begin
                state_d = id_legal ? S_EX : S_IF;
            end
            S_EX: begin
                if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_r || is_i) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_IF;
                end
            end
            S_MEM: begin
                if (!bus.mem_ready) begin
                    state_d = S_MEM;
                end else if (is_lw) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_IF;
                end
            end
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    // Per-state control decode, all quiet while reset is held
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = 2'b00;
        illegal    = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_IF: begin
                    mem_read = 1'b1;
                    ir_write = bus.mem_ready;
                    pc_write = bus.mem_ready;
                end
                S_ID: begin
                    illegal = !id_legal;
                end
                S_EX: begin
                    alu_src_b = is_i || is_lw || is_sw;
                    if (is_r) begin
                        alu_op = 2'b10;
                    end else if (is_i) begin
                        alu_op = 2'b11;
                    end else if (is_beq) begin
                        alu_op   = 2'b01;
                        pc_src   = 1'b1;
                        pc_write = bus.zero;
                    end
                end
                S_MEM: begin
                    mem_read  = is_lw;
                    mem_write = is_sw;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = is_lw;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.ir_write   = ir_write;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.reg_write  = reg_write;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.illegal    = illegal;
    assign bus.state      = rst_n ? state_q : 3'd0;

`ifdef MC_CTRL_PERF_CNT_EN
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic             retire;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] ret_q;

    assign retire = (state_q == S_WB)
                 || (state_q == S_MEM && is_sw && bus.mem_ready)
                 || (state_q == S_EX && is_beq);

    // Free-running cycle count and retired-instruction count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_q + ONE;
            if (retire) begin
                ret_q <= ret_q + ONE;
            end
        end
    end

    assign bus.cycle_cnt   = rst_n ? cyc_q : '0;
    assign bus.instret_cnt = rst_n ? ret_q : '0;
`else
    assign bus.cycle_cnt   = '0;
    assign bus.instret_cnt = '0;
`endif
endmodule
